// File: rtl/seg_disp_pkg.sv
// Shared 7-segment definitions: active-low glyph table, page FSM states and a
// width helper that never returns zero.
package seg_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Bit order {g,f,e,d,c,b,a}, active low; entry n is digit n
   localparam logic [9:0][6:0] DIGIT_GLYPH = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic {
      AUTO_DWELL = 1'b0,
      MANUAL     = 1'b1
   } page_state_e;

   function automatic logic [6:0] glyph(input logic [3:0] value);
      if (value <= 4'd9) begin
         return DIGIT_GLYPH[value];
      end
      return SEG_BLANK;
   endfunction

   function automatic int unsigned width_of(input int unsigned count);
      return (count <= 1) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD to active-low 7-segment decoder; non-decimal codes render blank.
module seg_decoder
   import seg_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_c
);

   assign seg_c = glyph(bcd);

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-page, multi-digit 7-segment scan controller with blink, leading-zero
// blanking, decimal points and inter-digit ghost blanking.
module seg_display_ctrl
   import seg_disp_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned N_DIGITS  = 4,
   parameter int unsigned N_PAGES   = 3,
   parameter int unsigned SCAN_HZ   = 1000,
   parameter int unsigned GHOST_CYC = 100,
   parameter int unsigned BLINK_HZ  = 2,
   parameter int unsigned PAGE_SEC  = 3,
   localparam int unsigned PAGE_W   = width_of(N_PAGES)
)
(
   input  logic                            clk_100MHz,
   input  logic                            reset,
   input  logic [N_PAGES*N_DIGITS*4-1:0]   page_data,
   input  logic [N_PAGES*N_DIGITS-1:0]     dp_mask,
   input  logic [N_DIGITS-1:0]             blink_mask,
   input  logic                            lz_en,
   input  logic                            auto_mode,
   input  logic                            page_next,
   input  logic                            sec_tick,
   output logic [6:0]                      seg,
   output logic                            dp,
   output logic [N_DIGITS-1:0]             an,
   output logic [PAGE_W-1:0]               page_idx
);

   localparam int unsigned SLOT     = CLK_HZ / (SCAN_HZ * N_DIGITS);
   localparam int unsigned BLINK_TC = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned SLOT_W   = width_of(SLOT);
   localparam int unsigned BLINK_W  = width_of(BLINK_TC);
   localparam int unsigned DWELL_W  = width_of(PAGE_SEC);
   localparam int unsigned DIG_W    = width_of(N_DIGITS);

   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [DIG_W-1:0]    digit_q, digit_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                blink_hidden_q, blink_hidden_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [PAGE_W-1:0]   page_q, page_d;
   page_state_e         state_q, state_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [N_DIGITS-1:0] an_q, an_d;

   logic [3:0]          cur_digit [N_DIGITS];
   logic [3:0]          nibble;
   logic [6:0]          glyph_c;
   logic                advance;
   logic                upper_zero;
   logic                blank;

   // Scan position and free-running blink phase
   always_comb begin
      slot_d         = slot_q + SLOT_W'(1);
      digit_d        = digit_q;
      blink_cnt_d    = blink_cnt_q + BLINK_W'(1);
      blink_hidden_d = blink_hidden_q;
      if (slot_q == SLOT_W'(SLOT - 1)) begin
         slot_d  = '0;
         digit_d = (digit_q == DIG_W'(N_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
      end
      if (blink_cnt_q == BLINK_W'(BLINK_TC - 1)) begin
         blink_cnt_d    = '0;
         blink_hidden_d = ~blink_hidden_q;
      end
   end

   // Page FSM: dwell counts ticks only while auto rotation is selected
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      advance = 1'b0;
      case (state_q)
         MANUAL:     if (auto_mode) state_d = AUTO_DWELL;
         AUTO_DWELL: if (!auto_mode) state_d = MANUAL;
         default:    state_d = MANUAL;
      endcase
      if (!auto_mode) begin
         dwell_d = '0;
      end else if (sec_tick) begin
         if (dwell_q == DWELL_W'(PAGE_SEC - 1)) begin
            advance = 1'b1;
            dwell_d = '0;
         end else begin
            dwell_d = dwell_q + DWELL_W'(1);
         end
      end
      // A simultaneous expiry and manual step still advance only once
      if (page_next) begin
         advance = 1'b1;
         dwell_d = '0;
      end
      page_d = page_q;
      if (advance) begin
         page_d = (page_q == PAGE_W'(N_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
      end
   end

   // Current page digits and leading-zero detection above the scanned digit
   always_comb begin
      upper_zero = 1'b1;
      for (int d = 0; d < int'(N_DIGITS); d++) begin
         cur_digit[d] = page_data[(int'(page_q) * int'(N_DIGITS) + d) * 4 +: 4];
         if (d >= int'(digit_q) && cur_digit[d] != 4'd0) begin
            upper_zero = 1'b0;
         end
      end
      nibble = cur_digit[digit_q];
      blank  = (lz_en && digit_q != '0 && upper_zero) ||
               (blink_mask[digit_q] && blink_hidden_q);
   end

   seg_decoder u_seg_decoder (
      .bcd   (nibble),
      .seg_c (glyph_c)
   );

   // Output stage; the ghost window keeps all anodes dark at each slot start
   always_comb begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      an_d  = '1;
      if (slot_q >= SLOT_W'(GHOST_CYC)) begin
         seg_d = blank ? SEG_BLANK : glyph_c;
         dp_d  = ~dp_mask[int'(page_q) * int'(N_DIGITS) + int'(digit_q)];
         an_d  = ~(N_DIGITS'(1) << digit_q);
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         slot_q         <= '0;
         digit_q        <= '0;
         blink_cnt_q    <= '0;
         blink_hidden_q <= 1'b0;
         dwell_q        <= '0;
         page_q         <= '0;
         state_q        <= MANUAL;
         seg_q          <= SEG_BLANK;
         dp_q           <= 1'b1;
         an_q           <= '1;
      end else begin
         slot_q         <= slot_d;
         digit_q        <= digit_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_hidden_q <= blink_hidden_d;
         dwell_q        <= dwell_d;
         page_q         <= page_d;
         state_q        <= state_d;
         seg_q          <= seg_d;
         dp_q           <= dp_d;
         an_q           <= an_d;
      end
   end

   assign seg      = seg_q;
   assign dp       = dp_q;
   assign an       = an_q;
   assign page_idx = page_q;

endmodule
